serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop processes one bit pair per clock, LSB first.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_carry_cell.sv | 47 ++++
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e          : FSM state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH    : default operand width
//   cnt_width()      : bit counter width for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The counter only has to reach WIDTH-1. Clamp to at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_carry_cell.sv
// One full-adder cell plus the carry flop that is threaded through the
// bit-serial addition.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load carry flop from cin_i (operation accept)
//   en_i          : advance carry flop with this cycle's carry out
//   cin_i         : carry-in captured on load
//   a_i, b_i      : current operand bit pair
//   s_o           : sum bit of the current pair
//   c_next_o      : carry out of the current pair
module serial_carry_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    input  logic cin_i,
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_next_o
);

    logic carry_q;
    logic carry_d;
    logic half_s;

    assign half_s   = a_i ^ b_i;
    assign s_o      = half_s ^ carry_q;
    assign c_next_o = (a_i & b_i) | (carry_q & half_s);

    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = cin_i;
        end else if (en_i) begin
            carry_d = c_next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit pair per clock.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf_o port
// (signed overflow of the last completed addition).
//   clk_i    : clock
//   rst_ni   : async active-low reset
//   start_i  : request, accepted in IDLE or DONE
//   a_i, b_i : operands, captured on the accepting edge
//   cin_i    : carry-in, captured on the accepting edge
//   busy_o   : high while an addition is in progress
//   done_o   : one-cycle pulse when sum_o/cout_o are valid
//   sum_o    : result, held until the next accept
//   cout_o   : carry out of bit WIDTH-1, held like sum_o
//   ovf_o    : (SERIAL_ADDER_OVF_EN only) signed overflow, held like cout_o
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | processing one bit pair per clock
// DONE  | result valid, done pulse; start here restarts immediately
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
    logic             cout_q, done_q;
    logic             accept, run, last;
    logic             s_bit, c_next;

    assign run    = (state_q == RUN);
    assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign last   = run && (count_q == LAST_CNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (count_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = run;
        done_o = done_q;
        sum_o  = sum_q;
        cout_o = cout_q;
    end

    serial_carry_cell u_cell (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (accept),
        .en_i     (run),
        .cin_i    (cin_i),
        .a_i      (a_sr_q[0]),
        .b_i      (b_sr_q[0]),
        .s_o      (s_bit),
        .c_next_o (c_next)
    );

    // sum_q is not cleared on accept; it is simply refilled by WIDTH shifts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_sr_q  <= a_i;
                b_sr_q  <= b_i;
                count_q <= '0;
            end else if (run) begin
                a_sr_q  <= a_sr_q >> 1;
                b_sr_q  <= b_sr_q >> 1;
                sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
                count_q <= count_q + 1'b1;
                if (last) begin
                    cout_q <= c_next;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the MSB is recovered from the cell: a ^ b ^ s.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= a_sr_q[0] ^ b_sr_q[0] ^ s_bit ^ c_next;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        cin32 = 1'b0;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf8, ovf2, ovf32;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_o(ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .a_i(a2), .b_i(b2), .cin_i(cin2),
        .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_o(ovf2)
`endif
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .a_i(a32), .b_i(b32), .cin_i(cin32),
        .busy_o(busy32), .done_o(done32), .sum_o(sum32), .cout_o(cout32)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_o(ovf32)
`endif
    );

    // Pulse start on the 8-bit instance and wait (bounded) for done.
    // cyc = number of negedges after the first RUN edge, -1 on timeout.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int cyc, output logic busy_seen);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy_seen = busy8;
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done8) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf8);
        end
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy8, done8, sum8, cout8} !== 11'd0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got busy=%b done=%b sum=%h cout=%b, want all 0",
                         i, busy8, done8, sum8, cout8);
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic bs;
        do_op8(8'h3C, 8'h05, 1'b0, cyc, bs);
        checks++;
        if (bs !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", bs);
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 8", cyc);
        end
        checks++;
        if (sum8 !== 8'h41 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got sum=%h cout=%b want sum=41 cout=0", sum8, cout8);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sum8 !== 8'h41 || cout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold cycle %0d: got sum=%h cout=%b done=%b busy=%b want 41 0 0 0",
                         i, sum8, cout8, done8, busy8);
            end
        end
    endtask

    task automatic test_carry();
        int cyc;
        logic bs;
        do_op8(8'hFF, 8'h00, 1'b1, cyc, bs);
        checks++;
        if (cyc !== 8 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            errors++;
            $display("FAIL carry_ripple: got cyc=%0d sum=%h cout=%b want 8 00 1", cyc, sum8, cout8);
        end
        do_op8(8'h80, 8'h80, 1'b0, cyc, bs);
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            errors++;
            $display("FAIL carry_msb: got sum=%h cout=%b want 00 1", sum8, cout8);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: got %b want 1", ovf8);
        end
        do_op8(8'h7F, 8'h01, 1'b0, cyc, bs);
        checks++;
        if (sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b want 80 0 1", sum8, cout8, ovf8);
        end
        do_op8(8'hFF, 8'h01, 1'b0, cyc, bs);
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_none: got sum=%h cout=%b ovf=%b want 00 1 0", sum8, cout8, ovf8);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int first_done, done_cnt, prev_done;
        logic [7:0] a_hold;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        first_done = -1; prev_done = -1; done_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done8) begin
                done_cnt++;
                checks++;
                if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result: got sum=%h cout=%b want 46 0", sum8, cout8);
                end
                if (first_done < 0) begin
                    first_done = n;
                end else begin
                    checks++;
                    if (n - prev_done !== 9) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d want 9", n - prev_done);
                    end
                end
                prev_done = n;
            end
        end
        start8 = 1'b0;
        checks++;
        if (first_done !== 9 || done_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_pulses: got first=%0d count=%0d want first=9 count=3", first_done, done_cnt);
        end
        repeat (12) @(negedge clk);

        // start mid-RUN is ignored and operand changes do not matter
        a8 = 8'h55; b8 = 8'h0A; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
        first_done = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) start8 = 1'b1;
            if (n == 4) start8 = 1'b0;
            if (done8) begin
                first_done = n;
                break;
            end
        end
        a_hold = sum8;
        checks++;
        if (first_done !== 8 || a_hold !== 8'h60 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_midrun: got cyc=%0d sum=%h cout=%b want 8 60 0", first_done, a_hold, cout8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart: got done=%b busy=%b want 0 0", done8, busy8);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic bs;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op8(8'h01, 8'h01, 1'b0, cyc, bs);
        checks++;
        if (cyc !== 8 || sum8 !== 8'h02 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got cyc=%0d sum=%h cout=%b want 8 02 0", cyc, sum8, cout8);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic        rc;
        logic [2:0]  e2;
        logic [8:0]  e8;
        logic [32:0] e32;
        int seen2, seen8, seen32;
        int bad;
        bad = 0;
        for (int it = 0; it < 1000; it++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (it == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1; end
            e2  = {1'b0, ra[1:0]} + {1'b0, rb[1:0]} + {2'b0, rc};
            e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'b0, rc};
            e32 = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            @(negedge clk);
            a2 = ra[1:0]; b2 = rb[1:0]; cin2 = rc; start2 = 1'b1;
            a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc; start8 = 1'b1;
            a32 = ra; b32 = rb; cin32 = rc; start32 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
            seen2 = 0; seen8 = 0; seen32 = 0;
            for (int n = 1; n <= 34; n++) begin
                @(negedge clk);
                if (done2) begin
                    seen2++;
                    checks++;
                    if ({cout2, sum2} !== e2 || n !== 2) begin
                        errors++; bad++;
                        if (bad < 10) $display("FAIL rand_w2: got %h at %0d want %h at 2", {cout2, sum2}, n, e2);
                    end
                end
                if (done8) begin
                    seen8++;
                    checks++;
                    if ({cout8, sum8} !== e8 || n !== 8) begin
                        errors++; bad++;
                        if (bad < 10) $display("FAIL rand_w8: got %h at %0d want %h at 8", {cout8, sum8}, n, e8);
                    end
                end
                if (done32) begin
                    seen32++;
                    checks++;
                    if ({cout32, sum32} !== e32 || n !== 32) begin
                        errors++; bad++;
                        if (bad < 10) $display("FAIL rand_w32: got %h at %0d want %h at 32", {cout32, sum32}, n, e32);
                    end
                end
            end
            checks++;
            if (seen2 !== 1 || seen8 !== 1 || seen32 !== 1) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_done_count: got %0d/%0d/%0d want 1/1/1", seen2, seen8, seen32);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
